pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, synchronous flush and
//  optional 2-entry skid buffer. Next-generation stage register for the pipelined RISC-V
//  datapath (IF/ID, ID/EX, EX/MEM, MEM/WB); lets back-pressure stall one stage at a time
//  without a combinational ready chain. Flushed or empty entries present CLEAR_VALUE (NOP bubble).
// PARAMETERS
//  WIDTH        96   payload bits (e.g. {Instr,PC,PCPlus4} = 3x32)
//  SKID         1    1: 2-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
//  CLEAR_VALUE  0    payload driven/loaded on reset, flush and whenever an entry is empty
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      synchronous clear of all entries (branch mispredict / hazard squash)
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept; transfer when in_valid & in_ready
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      downstream payload valid
//  out_ready  in   1      downstream accepts; transfer when out_valid & out_ready
//  out_data   out  WIDTH  registered payload (CLEAR_VALUE when out_valid=0)
//  occupancy  out  2      entries held: 0, 1, or 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=CLEAR_VALUE, skid entry invalid/CLEAR_VALUE, occupancy=0,
//    in_ready=1 (SKID=1) or =1 via empty stage (SKID=0). Reset has priority over flush and handshake.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency in->out: 1 cycle.
//  - State = occupancy: EMPTY(0), HALF(1: main valid), FULL(2: main+skid valid).
//    EMPTY: in_fire -> HALF, main<=in_data.
//    HALF : in_fire & out_fire -> HALF, main<=in_data;
//           in_fire & !out_fire -> FULL, skid<=in_data (SKID=1 only);
//           !in_fire & out_fire -> EMPTY, main<=CLEAR_VALUE;  neither -> hold.
//    FULL : in_ready=0; out_fire -> HALF, main<=skid, skid<=CLEAR_VALUE; else hold.
//  - SKID=1: in_ready = (occupancy!=2), purely registered; no path from out_ready to in_ready.
//  - SKID=0: in_ready = !out_valid | out_ready (combinational); FULL unreachable;
//    HALF & in_fire & !out_fire cannot occur.
//  - Order preserved: main always older than skid; no beat dropped or duplicated except by flush.
//  - flush=1: next cycle occupancy=0, out_valid=0, all entries CLEAR_VALUE; a beat accepted
//    (in_fire) in the flush cycle is discarded; out_fire in the flush cycle still counts as
//    delivered downstream. in_ready not gated by flush.
//  - Held payload is stable while out_valid & !out_ready (no change to out_data).
//  - in_data ignored when in_valid=0; out_data never X after reset.
// TESTING
//  1 Reset mid-stream: FULL with A,B, assert reset 1 cycle -> next cycle occupancy=0,
//    out_valid=0, out_data=0, in_ready=1.
//  2 Streaming: out_ready=1, in_valid=1 with 0x1..0x8 on consecutive cycles -> out_data
//    0x1..0x8 one cycle later, one per cycle, occupancy stays 1.
//  3 Back-pressure (SKID=1): send A,B,C with out_ready=0 -> A held on out, B in skid,
//    in_ready=0 at occupancy 2, C stalls upstream; release out_ready -> A,B,C in order, no loss.
//  4 Flush while FULL with in_fire: hold A,B, raise flush with C offered -> next cycle
//    occupancy=0, out_valid=0; C never appears on output.
//  5 SKID=0 build: out_ready=0 with A held -> in_ready=0 same cycle; out_ready=1 ->
//    in_ready=1 same cycle, A out and B in on same edge.
//  6 Random valid/ready (10k cycles, both SKID values) -> scoreboard exact in-order match,
//    occupancy never >2 (>1 for SKID=0), out_data stable while stalled.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, synchronous flush and an optional
// second (skid) entry so back-pressure does not form a combinational ready chain.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH       = 96,
   parameter int unsigned      SKID        = 1,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // state | meaning
   // EMPTY | no entry held, out_data shows CLEAR_VALUE
   // HALF  | main entry valid and presented downstream
   // FULL  | main and skid valid, skid is the younger beat (SKID=1 only)
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   generate
      if (SKID != 0) begin : g_skid
         // Decoded straight from the state register: no path from out_ready.
         assign in_ready = (state_q != FULL);
      end else begin : g_noskid
         assign in_ready = (state_q == EMPTY) | out_ready;
      end
   endgenerate

   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = CLEAR_VALUE;
         skid_d  = CLEAR_VALUE;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = HALF;
                  main_d  = in_data;
               end
            end
            HALF: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire && (SKID != 0)) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
                  main_d  = CLEAR_VALUE;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d = HALF;
                  main_d  = skid_q;
                  skid_d  = CLEAR_VALUE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = CLEAR_VALUE;
               skid_d  = CLEAR_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= CLEAR_VALUE;
         skid_q  <= CLEAR_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share stimulus and are each
// checked against a queue model of the stage.
module tb_pipe_stage_reg;

   localparam int W = 96;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [W-1:0]  in_data;
   logic          rdy1, ov1, rdy0, ov0;
   logic [W-1:0]  od1, od0;
   logic [1:0]    occ1, occ0;

   logic [W-1:0]  m1[$];
   logic [W-1:0]  m0[$];
   logic          e_rdy1, e_ov1, e_rdy0, e_ov0;
   logic [W-1:0]  e_od1, e_od0;
   logic [1:0]    e_occ1, e_occ0;

   int passed = 0;
   int total  = 0;

   localparam logic [W-1:0] A = 96'h0000_00A1_1111_2222_3333_4444;
   localparam logic [W-1:0] B = 96'h0000_00B2_5555_6666_7777_8888;
   localparam logic [W-1:0] C = 96'h0000_00C3_9999_AAAA_BBBB_CCCC;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(W), .SKID(1), .CLEAR_VALUE('0)) u_skid1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

   pipe_stage_reg #(.WIDTH(W), .SKID(0), .CLEAR_VALUE('0)) u_skid0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0));

   // Expected outputs derived from the queue contents and the current inputs.
   function automatic void compute_exp();
      e_occ1 = 2'(m1.size());
      e_ov1  = (m1.size() != 0);
      e_od1  = e_ov1 ? m1[0] : '0;
      e_rdy1 = (m1.size() < 2);
      e_occ0 = 2'(m0.size());
      e_ov0  = (m0.size() != 0);
      e_od0  = e_ov0 ? m0[0] : '0;
      e_rdy0 = (m0.size() == 0) || out_ready;
   endfunction

   task automatic setup(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      compute_exp();
      @(negedge clk);
   endtask

   task automatic commit();
      if (reset || flush) begin
         m1.delete();
         m0.delete();
      end else begin
         if (e_ov1 && out_ready) void'(m1.pop_front());
         if (in_valid && e_rdy1) m1.push_back(in_data);
         if (e_ov0 && out_ready) void'(m0.pop_front());
         if (in_valid && e_rdy0) m0.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      setup(1'b1, 1'b0, 1'b0, '0, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b0, '1, 1'b0);
      total++;
      if ({rdy1, ov1, occ1, od1} !== {1'b1, 1'b0, 2'd0, {W{1'b0}}})
         $display("FAIL reset_skid1 got rdy=%b v=%b occ=%0d d=%h want rdy=1 v=0 occ=0 d=0",
                  rdy1, ov1, occ1, od1);
      else passed++;
      total++;
      if ({rdy0, ov0, occ0, od0} !== {1'b1, 1'b0, 2'd0, {W{1'b0}}})
         $display("FAIL reset_skid0 got rdy=%b v=%b occ=%0d d=%h want rdy=1 v=0 occ=0 d=0",
                  rdy0, ov0, occ0, od0);
      else passed++;
      commit();
   endtask

   task automatic test_reset_mid_stream();
      setup(1'b0, 1'b0, 1'b1, A, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b1, B, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b0, C, 1'b0);
      total++;
      if ({occ1, od1} !== {2'd2, A})
         $display("FAIL midrst_full got occ=%0d d=%h want occ=2 d=%h", occ1, od1, A);
      else passed++;
      setup(1'b1, 1'b0, 1'b1, C, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b0, '0, 1'b0);
      total++;
      if ({rdy1, ov1, occ1, od1} !== {1'b1, 1'b0, 2'd0, {W{1'b0}}})
         $display("FAIL midrst_after got rdy=%b v=%b occ=%0d d=%h want rdy=1 v=0 occ=0 d=0",
                  rdy1, ov1, occ1, od1);
      else passed++;
      total++;
      if ({rdy0, ov0, occ0} !== {1'b1, 1'b0, 2'd0})
         $display("FAIL midrst_after_s0 got rdy=%b v=%b occ=%0d want rdy=1 v=0 occ=0",
                  rdy0, ov0, occ0);
      else passed++;
      commit();
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 9; k++) begin
         setup(1'b0, 1'b0, (k <= 8), W'(k), 1'b1);
         if (k >= 2) begin
            total++;
            if ({ov1, occ1, od1} !== {1'b1, 2'd1, W'(k - 1)})
               $display("FAIL stream_s1 beat %0d got v=%b occ=%0d d=%h want v=1 occ=1 d=%0h",
                        k - 1, ov1, occ1, od1, k - 1);
            else passed++;
            total++;
            if ({ov0, occ0, od0} !== {1'b1, 2'd1, W'(k - 1)})
               $display("FAIL stream_s0 beat %0d got v=%b occ=%0d d=%h want v=1 occ=1 d=%0h",
                        k - 1, ov0, occ0, od0, k - 1);
            else passed++;
         end
         commit();
      end
      setup(1'b0, 1'b0, 1'b0, '0, 1'b1);
      commit();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp_seq[3];
      exp_seq = '{A, B, C};
      setup(1'b0, 1'b0, 1'b1, A, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b1, B, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b1, C, 1'b0);
      total++;
      if ({rdy1, occ1, od1} !== {1'b0, 2'd2, A})
         $display("FAIL bp_full got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=%h",
                  rdy1, occ1, od1, A);
      else passed++;
      commit();
      setup(1'b0, 1'b0, 1'b1, C, 1'b0);
      total++;
      if ({rdy1, od1} !== {1'b0, A})
         $display("FAIL bp_hold got rdy=%b d=%h want rdy=0 d=%h", rdy1, od1, A);
      else passed++;
      commit();
      for (int k = 0; k < 3; k++) begin
         setup(1'b0, 1'b0, (k < 2), C, 1'b1);
         total++;
         if ({ov1, od1} !== {1'b1, exp_seq[k]})
            $display("FAIL bp_drain %0d got v=%b d=%h want v=1 d=%h", k, ov1, od1, exp_seq[k]);
         else passed++;
         commit();
      end
      setup(1'b0, 1'b0, 1'b0, '0, 1'b1);
      total++;
      if (ov1 !== 1'b0)
         $display("FAIL bp_empty got v=%b want v=0", ov1);
      else passed++;
      commit();
      setup(1'b1, 1'b0, 1'b0, '0, 1'b1);
      commit();
   endtask

   task automatic test_flush_full();
      setup(1'b0, 1'b0, 1'b1, A, 1'b0);
      commit();
      setup(1'b0, 1'b0, 1'b1, B, 1'b0);
      commit();
      setup(1'b0, 1'b1, 1'b1, C, 1'b1);
      commit();
      for (int k = 0; k < 3; k++) begin
         setup(1'b0, 1'b0, 1'b0, C, 1'b1);
         total++;
         if ({ov1, occ1, od1} !== {1'b0, 2'd0, {W{1'b0}}})
            $display("FAIL flush_s1 cyc %0d got v=%b occ=%0d d=%h want v=0 occ=0 d=0",
                     k, ov1, occ1, od1);
         else passed++;
         total++;
         if ({ov0, occ0, od0} !== {1'b0, 2'd0, {W{1'b0}}})
            $display("FAIL flush_s0 cyc %0d got v=%b occ=%0d d=%h want v=0 occ=0 d=0",
                     k, ov0, occ0, od0);
         else passed++;
         commit();
      end
   endtask

   task automatic test_skid0();
      setup(1'b0, 1'b0, 1'b1, A, 1'b1);
      commit();
      setup(1'b0, 1'b0, 1'b1, B, 1'b0);
      total++;
      if ({rdy0, ov0, od0} !== {1'b0, 1'b1, A})
         $display("FAIL s0_stall got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h", rdy0, ov0, od0, A);
      else passed++;
      commit();
      setup(1'b0, 1'b0, 1'b1, B, 1'b1);
      total++;
      if ({rdy0, od0} !== {1'b1, A})
         $display("FAIL s0_release got rdy=%b d=%h want rdy=1 d=%h", rdy0, od0, A);
      else passed++;
      commit();
      setup(1'b0, 1'b0, 1'b0, '0, 1'b1);
      total++;
      if ({ov0, occ0, od0} !== {1'b1, 2'd1, B})
         $display("FAIL s0_swap got v=%b occ=%0d d=%h want v=1 occ=1 d=%h", ov0, occ0, od0, B);
      else passed++;
      commit();
      setup(1'b1, 1'b0, 1'b0, '0, 1'b1);
      commit();
   endtask

   task automatic test_random();
      logic         stall1, stall0;
      logic [W-1:0] held1, held0;
      logic         r, f, iv, ordy;
      logic [W-1:0] d;
      stall1 = 1'b0;
      stall0 = 1'b0;
      held1  = '0;
      held0  = '0;
      for (int n = 0; n < 10000; n++) begin
         r    = ($urandom_range(0, 499) == 0);
         f    = ($urandom_range(0, 39) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         d    = {$urandom(), $urandom(), $urandom()};
         setup(r, f, iv, d, ordy);
         total++;
         if ({rdy1, ov1, occ1, od1} !== {e_rdy1, e_ov1, e_occ1, e_od1}) begin
            if (total - passed < 20)
               $display("FAIL rnd_s1 cyc %0d got rdy=%b v=%b occ=%0d d=%h want rdy=%b v=%b occ=%0d d=%h",
                        n, rdy1, ov1, occ1, od1, e_rdy1, e_ov1, e_occ1, e_od1);
         end else passed++;
         total++;
         if ({rdy0, ov0, occ0, od0} !== {e_rdy0, e_ov0, e_occ0, e_od0}) begin
            if (total - passed < 20)
               $display("FAIL rnd_s0 cyc %0d got rdy=%b v=%b occ=%0d d=%h want rdy=%b v=%b occ=%0d d=%h",
                        n, rdy0, ov0, occ0, od0, e_rdy0, e_ov0, e_occ0, e_od0);
         end else passed++;
         if (stall1) begin
            total++;
            if (od1 !== held1) begin
               if (total - passed < 20)
                  $display("FAIL rnd_stable_s1 cyc %0d got d=%h want d=%h", n, od1, held1);
            end else passed++;
         end
         if (stall0) begin
            total++;
            if (od0 !== held0) begin
               if (total - passed < 20)
                  $display("FAIL rnd_stable_s0 cyc %0d got d=%h want d=%h", n, od0, held0);
            end else passed++;
         end
         total++;
         if (occ1 > 2'd2 || occ0 > 2'd1) begin
            if (total - passed < 20)
               $display("FAIL rnd_occ cyc %0d got occ1=%0d occ0=%0d want occ1<=2 occ0<=1",
                        n, occ1, occ0);
         end else passed++;
         stall1 = e_ov1 && !ordy && !r && !f;
         stall0 = e_ov0 && !ordy && !r && !f;
         held1  = e_od1;
         held0  = e_od0;
         commit();
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_reset_mid_stream();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_skid0();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
